// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit peripheral (states, register map, STATUS layout).
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package uart_tx_pkg;

    typedef logic [2:0] state_t;

    // Serialiser states; PARITY is only entered when parity generation is built in.
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;

    // Register word offsets within the 16-byte window (address[3:2]).
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    // STATUS bit positions.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_PARITY  = 8;

    // A divider of zero would stall the bit counter, so it is run as one cycle per bit.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_peripheral_if.sv
// Data-memory bus as seen by a memory-mapped responder: store strobe/address/data, load address/data.
// Latency: load data returns one cycle after the load address (set by the responder).
// Backpressure: none; stores are single-cycle strobes and always complete.
interface uart_tx_peripheral_if;
    logic        write_mem;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;

    modport master (
        output write_mem, write_address, write_data, read_address,
        input  read_data
    );

    modport slave (
        input  write_mem, write_address, write_data, read_address,
        output read_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational head (dout) and occupancy count.
// Latency: a pushed entry is visible on dout/empty the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter: stores to TXDATA queue bytes, serialised 8N1 LSB-first on tx (parity via UART_TX_PARITY_EN).
// Latency: loads return one cycle after read_address; a byte queued to an idle block starts its start bit two edges after the store.
// Backpressure: none on the bus; a TXDATA store to a full FIFO (with no pop that cycle) is dropped and sets sticky overflow.
module uart_tx_peripheral
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FFE0,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd104
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_peripheral_if.slave  bus,
    output logic                 tx,
    output logic                 irq_empty
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic   PARITY_EN  = 1'b1;
    localparam state_t AFTER_DATA = S_PARITY;
    logic parity;
`else
    localparam logic   PARITY_EN  = 1'b0;
    localparam state_t AFTER_DATA = S_STOP;
`endif

    logic [15:0]   baud_div;
    logic          overflow;
    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   period;
    logic          wr_hit;
    logic          rd_hit;
    logic          push_req;
    logic          pop;
    logic          bit_end;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign wr_hit    = bus.write_mem && (bus.write_address[31:4] == BASE_ADDR[31:4]);
    assign rd_hit    = (bus.read_address[31:4] == BASE_ADDR[31:4]);
    assign push_req  = wr_hit && (bus.write_address[3:2] == OFF_TXDATA);
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign bit_end   = (baud_cnt == period - 16'd1);
    assign irq_empty = fifo_empty && (state == S_IDLE);
    assign unused_bits = ^{bus.write_address[1:0], bus.read_address[1:0], bus.write_data[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (bus.write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Software-visible registers: baud divider and sticky overflow (W1C via STATUS bit3).
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div <= BAUD_DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_hit && bus.write_address[3:2] == OFF_BAUD)
                baud_div <= bus.write_data[15:0];
            if (push_req && fifo_full && !pop)
                overflow <= 1'b1;
            else if (wr_hit && bus.write_address[3:2] == OFF_STATUS && bus.write_data[STAT_OVF])
                overflow <= 1'b0;
        end
    end

    // Frame sequencer; the divider is latched at pop so mid-frame BAUD writes wait for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            period   <= 16'd1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else if (state == S_IDLE) begin
            if (!fifo_empty) begin
                shift    <= fifo_dout;
                period   <= bit_period(baud_div);
                baud_cnt <= '0;
                bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                parity   <= ^fifo_dout;
`endif
                state    <= S_START;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            case (state)
                S_START:  state <= S_DATA;
                S_DATA: begin
                    shift <= shift >> 1;
                    if (bit_idx == 3'd7) state <= AFTER_DATA;
                    else                 bit_idx <= bit_idx + 3'd1;
                end
                S_PARITY: state <= S_STOP;
                default:  state <= S_IDLE;
            endcase
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // Line driver: idle/stop high, start low, data LSB first.
    always_comb begin
        tx = 1'b1;
        case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = parity;
`endif
            default:  tx = 1'b1;
        endcase
    end

    // STATUS word assembly.
    always_comb begin
        status                         = '0;
        status[STAT_BUSY]              = (state != S_IDLE);
        status[STAT_FULL]              = fifo_full;
        status[STAT_EMPTY]             = fifo_empty;
        status[STAT_OVF]               = overflow;
        status[STAT_CNT_LSB +: 4]      = 4'(fifo_count);
        status[STAT_PARITY]            = PARITY_EN;
    end

    // Registered load path, matching memory read timing; zero outside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.read_data <= '0;
        end else if (!rd_hit) begin
            bus.read_data <= '0;
        end else begin
            case (bus.read_address[3:2])
                OFF_STATUS: bus.read_data <= status;
                OFF_BAUD:   bus.read_data <= {16'h0000, baud_div};
                default:    bus.read_data <= '0;
            endcase
        end
    end
endmodule
